// File: rtl/prbs_checker.sv
// Serial checker for the x^4 + x^3 + 1 PRBS (period 15): self-synchronises,
// then pulses and counts bit errors, dropping lock after a run of errors.
module prbs_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [7:0]       MATCH_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0]       LOSS_LAST  = 4'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Next bit of the sequence implied by the last four bits.
  function automatic logic prbs_next(input logic [3:0] s);
    return s[3] ^ s[2];
  endfunction

  state_t     state_r;
  logic [3:0] s_r;
  logic [1:0] seed_r;
  logic [7:0] match_r;
  logic [3:0] loss_r;

  logic       p_s;
  logic [3:0] shift_in_s;
  logic       err_s;

  // Prediction and error decode for the bit on the input this cycle.
  always_comb begin
    p_s        = prbs_next(s_r);
    shift_in_s = {s_r[2:0], in_bit};
    if (in_valid && (state_r == LOCK) && (in_bit != p_s)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Lock FSM, predictor, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HUNT;
      s_r       <= 4'd0;
      seed_r    <= 2'd0;
      match_r   <= 8'd0;
      loss_r    <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= {CNT_W{1'b0}};
    end else begin
      err_pulse <= err_s;
      // clear takes priority over a coincident counted error
      if (clear) begin
        err_cnt <= {CNT_W{1'b0}};
      end else if (err_s && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            s_r <= shift_in_s;
            if (seed_r == 2'd3) begin
              seed_r <= 2'd0;
              if (shift_in_s != 4'd0) begin
                state_r <= SYNC;
                match_r <= 8'd0;
              end
            end else begin
              seed_r <= seed_r + 2'd1;
            end
          end
          SYNC: begin
            s_r <= shift_in_s;
            if (in_bit == p_s) begin
              if (match_r == MATCH_LAST) begin
                state_r <= LOCK;
                locked  <= 1'b1;
                match_r <= 8'd0;
                loss_r  <= 4'd0;
              end else begin
                match_r <= match_r + 8'd1;
              end
            end else begin
              state_r <= HUNT;
              seed_r  <= 2'd0;
              match_r <= 8'd0;
            end
          end
          LOCK: begin
            // flywheel: the predictor ignores received bits while locked
            s_r <= {s_r[2:0], p_s};
            if (err_s) begin
              if (loss_r == LOSS_LAST) begin
                state_r <= HUNT;
                locked  <= 1'b0;
                seed_r  <= 2'd0;
                loss_r  <= 4'd0;
              end else begin
                loss_r <= loss_r + 4'd1;
              end
            end else begin
              loss_r <= 4'd0;
            end
          end
          default: begin
            state_r <= HUNT;
            locked  <= 1'b0;
            seed_r  <= 2'd0;
            match_r <= 8'd0;
            loss_r  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a reference model predicts every output
// cycle; a second instance with a 4-bit counter covers saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic seen_lock = 1'b0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
  );

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  // reference model state: 0 hunt, 1 sync, 2 locked
  int         m_state;
  logic [3:0] m_s;
  int         m_seed, m_match, m_loss, m_cnt, m_cnt4;
  logic       m_pulse;
  logic [3:0] g = 4'b0001;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_s = 4'd0; m_seed = 0; m_match = 0; m_loss = 0;
    m_cnt = 0; m_cnt4 = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic c);
    logic p;
    logic e;
    e = 1'b0;
    p = m_s[3] ^ m_s[2];
    if (v) begin
      if (m_state == 0) begin
        m_s = {m_s[2:0], b};
        m_seed++;
        if (m_seed == 4) begin
          m_seed = 0;
          if (m_s != 4'd0) begin m_state = 1; m_match = 0; end
        end
      end else if (m_state == 1) begin
        m_s = {m_s[2:0], b};
        if (b == p) begin
          m_match++;
          if (m_match == 8) begin m_state = 2; m_match = 0; m_loss = 0; end
        end else begin
          m_state = 0; m_seed = 0; m_match = 0;
        end
      end else begin
        m_s = {m_s[2:0], p};
        if (b != p) begin
          e = 1'b1;
          m_loss++;
          if (m_loss == 4) begin m_state = 0; m_seed = 0; m_loss = 0; end
        end else begin
          m_loss = 0;
        end
      end
    end
    m_pulse = e;
    if (c) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    exp_t e;
    in_valid = v; in_bit = b; clear = c;
    model_step(v, b, c);
    sb.push_back('{lk: (m_state == 2), pl: m_pulse, cnt: 16'(m_cnt), cnt4: 4'(m_cnt4)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("locked", int'(locked), int'(e.lk));
    check_val("err_pulse", int'(err_pulse), int'(e.pl));
    check_val("err_cnt", int'(err_cnt), int'(e.cnt));
    check_val("err_cnt4", int'(err_cnt4), int'(e.cnt4));
    if (err_pulse) pulses++;
    if (locked) seen_lock = 1'b1;
  endtask

  task automatic next_prbs(output logic b);
    b = g[3] ^ g[2];
    g = {g[2:0], b};
  endtask

  task automatic run_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_prbs(b);
      step(1'b1, b, 1'b0);
    end
  endtask

  task automatic send_err(input logic c);
    logic b;
    next_prbs(b);
    step(1'b1, ~b, c);
  endtask

  task automatic wait_lock(output int n);
    logic b;
    n = 0;
    do begin
      next_prbs(b);
      step(1'b1, b, 1'b0);
      n++;
    end while (!locked && n < 40);
  endtask

  // Asserts rst_n between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_err_pulse", int'(err_pulse), 0);
    check_val("rst_err_cnt", int'(err_cnt), 0);
    check_val("rst_err_cnt4", int'(err_cnt4), 0);
    model_reset();
    sb.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [6:0] pat;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // clean stream from seed 0001
    wait_lock(n);
    check_val("lock_bits", n, 12);
    run_clean(1000 - 12);
    check_val("clean_pulses", pulses, 0);
    check_val("clean_err_cnt", int'(err_cnt), 0);

    // isolated single-bit errors
    pulses = 0;
    send_err(1'b0);
    run_clean(99);
    send_err(1'b0);
    run_clean(99);
    send_err(1'b0);
    run_clean(5);
    check_val("single_pulses", pulses, 3);
    check_val("single_err_cnt", int'(err_cnt), 3);
    check_val("single_locked", int'(locked), 1);

    // four consecutive errors drop lock
    run_clean(1);
    clear = 1'b1;
    step(1'b1, g[3] ^ g[2], 1'b1);
    g = {g[2:0], g[3] ^ g[2]};
    for (int i = 0; i < 4; i++) send_err(1'b0);
    check_val("loss_err_cnt", int'(err_cnt), 4);
    check_val("loss_locked", int'(locked), 0);
    wait_lock(n);
    check_val("relock_bits", n, 12);

    // all-zero seed, then a period-7 pattern that can never pass as the PRBS
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    pat = 7'b1101000;
    for (int i = 0; i < 210; i++) step(1'b1, pat[i % 7], 1'b0);
    check_val("bad_seen_lock", int'(seen_lock), 0);
    check_val("bad_err_cnt", int'(err_cnt), 0);

    // lock with in_valid toggling 1/0
    do_reset();
    n = 0;
    do begin
      logic b;
      next_prbs(b);
      step(1'b1, b, 1'b0);
      step(1'b0, ~b, 1'b0);
      n++;
    end while (!locked && n < 40);
    check_val("gap_lock_cycles", 2 * n, 24);

    // counter saturation on the 4-bit instance
    run_clean(1);
    step(1'b1, g[3] ^ g[2], 1'b1);
    g = {g[2:0], g[3] ^ g[2]};
    for (int i = 0; i < 20; i++) begin
      send_err(1'b0);
      run_clean(1);
    end
    check_val("sat_err_cnt", int'(err_cnt), 20);
    check_val("sat_err_cnt4", int'(err_cnt4), 15);
    check_val("sat_locked", int'(locked), 1);

    // clear coincident with a counted error
    send_err(1'b1);
    check_val("clr_err_pulse", int'(err_pulse), 1);
    check_val("clr_err_cnt", int'(err_cnt), 0);
    run_clean(1);

    // async reset while locked with five errors counted
    for (int i = 0; i < 5; i++) begin
      send_err(1'b0);
      run_clean(1);
    end
    check_val("pre_rst_err_cnt", int'(err_cnt), 5);
    check_val("pre_rst_locked", int'(locked), 1);
    do_reset();
    wait_lock(n);
    check_val("post_rst_lock_bits", n, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random bit sequence checker for the 4-bit LFSR pattern x^4 + x^3 + 1 (period 15). It sits directly downstream of the 4-bit LFSR generator and consumes its serial output stream. It self-synchronises to the incoming stream, then flags and counts bit errors. It declares loss of lock after a run of consecutive errors and re-hunts automatically.

## Interface
- LOCK_CNT, 8: consecutive correct predictions required after seeding before lock is declared (1..255).
- LOSS_CNT, 4: consecutive errors while locked that force a return to hunting (1..15).
- CNT_W, 16: width of the saturating error counter.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_bit is a new sequence bit this cycle; when low, all state holds.
- in_bit  input  1  received serial bit.
- clear  input  1  synchronous clear of err_cnt; does not affect lock state.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse for each bit mismatch detected while LOCKED.
- err_cnt  output  CNT_W  saturating count of mismatches detected while LOCKED.

## Operation
- Predictor register s[3:0].
  - Predicted bit p = s[3] ^ s[2].
  - On every accepted bit (in_valid = 1), s shifts left. The shifted-in bit is in_bit in HUNT and SYNC, and p in LOCKED (flywheel: received errors do not corrupt the predictor).
- HUNT:
  - Shift in 4 valid bits (seed counter 0..3).
  - On the 4th bit, if the resulting s != 0, go to SYNC with match_cnt = 0.
  - If s == 0 (illegal all-zero state), restart the seed count and stay in HUNT.
- SYNC:
  - Each valid bit: if in_bit == p, match_cnt++. On the LOCK_CNT-th consecutive match, go to LOCKED.
  - Any mismatch: go to HUNT with seed counter = 0. The mismatching bit is not reused as a seed.
- LOCKED:
  - Each valid bit: if in_bit != p, pulse err_pulse, increment err_cnt (saturating at 2^CNT_W−1), and increment loss_cnt.
  - If in_bit == p, loss_cnt = 0.
  - When loss_cnt reaches LOSS_CNT, go to HUNT (seed counter 0, loss_cnt 0). The error that triggers the exit is still counted and pulsed.
- clear:
  - err_cnt <= 0 on the clock edge.
  - If clear and a counted error occur in the same cycle, clear wins: err_cnt = 0. err_pulse still fires.
- Errors in HUNT and SYNC are never counted or pulsed.
- in_valid = 0: state, s, all counters and outputs hold, except err_pulse, which is 0.

## Timing
- Reset (rst_n low, async):
  - State = HUNT.
  - s = 0, seed/match/loss counters = 0.
  - locked = 0, err_pulse = 0, err_cnt = 0.
  - Outputs take reset values immediately, without waiting for a clock edge.
- Reset deassertion is sampled synchronously: the first bit accepted is on the first rising edge with rst_n high.
- All outputs are registered.
  - err_pulse is high for exactly the cycle after the edge that accepted the erroneous bit.
  - err_cnt updates in that same cycle.
- locked rises the cycle after the edge accepting the LOCK_CNT-th match.
  - Minimum lock latency from reset with a clean stream: 4 + LOCK_CNT valid bits.
- locked falls the cycle after the edge accepting the LOSS_CNT-th consecutive error.
- Reset mid-operation aborts any state immediately; err_cnt is lost.
- Back-to-back valid bits every cycle are supported, with no throughput bubbles.

## Test plan
- Clean stream: reset, then a clean LFSR stream seeded 4'b0001 with in_valid = 1 every cycle and default parameters.
  - Expected: locked rises after exactly 12 valid bits; err_cnt stays 0 over 1000 bits; err_pulse never fires.
- Single-bit errors: after lock, invert one bit, then at bit positions 100 and 200 invert again.
  - Expected: err_pulse fires 3 times, one cycle after each bad bit; err_cnt = 3; locked stays 1.
- Loss of lock: after lock, invert 4 consecutive bits.
  - Expected: err_cnt = 4 and locked = 0 after the 4th error. With a clean stream resumed, locked returns after 12 further valid bits.
- All-zero seed and bad stream: feed 8 zeros, then a random non-PRBS stream.
  - Expected: locked never asserts; err_cnt stays 0.
- Gaps, saturation and clear:
  - Lock with in_valid toggled 1/0/1/0: lock takes 24 cycles (12 valid bits).
  - Force errors with CNT_W = 4: err_cnt saturates at 15.
  - Assert clear together with an error: err_cnt = 0 and err_pulse = 1.
- Async reset mid-stream: pull rst_n low between clock edges while locked with err_cnt = 5.
  - Expected: locked = 0 and err_cnt = 0 immediately; relock after 12 bits.
